// File: rtl/pipe_dmem_responder_pkg.sv
// pipe_mem_pkg: shared types and constants for the data-memory responder
package pipe_mem_pkg;
  localparam int XLEN = 32;
  localparam int AW = 32;
  localparam int DEF_DEPTH = 128;
  localparam int DEF_LATENCY = 2;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/pipe_dmem_responder_if.sv
// pipe_dmem_if: request/response handshake between the MEM stage and the responder
interface pipe_dmem_if;
  import pipe_mem_pkg::*;
  logic req_valid_i, req_ready_o, req_write_i;
  logic [AW-1:0] req_addr_i;
  logic [XLEN-1:0] req_wdata_i, rsp_rdata_o;
  logic rsp_valid_o, rsp_ready_i, rsp_err_o, busy_o;
  modport master (output req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
                  input req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o);
  modport slave (input req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
                 output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o);
endinterface

// File: rtl/pipe_dmem_responder_array.sv
// dmem_array: word array with synchronous write and asynchronous read, not reset
module dmem_array
  import pipe_mem_pkg::*;
#(parameter int DEPTH = DEF_DEPTH) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [XLEN-1:0]          wdata_i,
  output logic [XLEN-1:0]          rdata_o
);
  logic [XLEN-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i) if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/pipe_dmem_responder.sv
// pipe_dmem_responder: one-at-a-time load/store responder with fixed access latency
module pipe_dmem_responder
  import pipe_mem_pkg::*;
#(parameter int DEPTH = DEF_DEPTH, parameter int LATENCY = DEF_LATENCY) (
  input logic       clk_i,
  input logic       rst_n,
  pipe_dmem_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic write_q, write_d, err_q, err_d, accept, commit, err;
  logic [AW-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d, rdata_q, rdata_d, rd;
  assign accept = state_q == IDLE && bus.req_valid_i;
  assign commit = state_q == WAIT && cnt_q == '0;
  // any set bit above the index field is out of range, so nothing wraps onto a valid word
  assign err = (|addr_q[1:0]) | (|addr_q[AW-1:IW+2]);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (bus.req_valid_i) begin state_d = WAIT; cnt_d = CW'(LATENCY - 1); end
      WAIT: if (cnt_q == '0) state_d = RESP; else cnt_d = cnt_q - CW'(1);
      RESP: if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    write_d = accept ? bus.req_write_i : write_q;
    addr_d = accept ? bus.req_addr_i : addr_q;
    wdata_d = accept ? bus.req_wdata_i : wdata_q;
    err_d = commit ? err : err_q;
    rdata_d = commit ? ((write_q || err) ? '0 : rd) : rdata_q;
  end
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      write_q <= write_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  end
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk_i   (clk_i),
    .we_i    (commit && write_q && !err),
    .addr_i  (addr_q[IW+1:2]),
    .wdata_i (wdata_q),
    .rdata_o (rd)
  );
  assign bus.req_ready_o = state_q == IDLE;
  assign bus.rsp_valid_o = state_q == RESP;
  assign bus.busy_o = state_q != IDLE;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o = err_q;
endmodule

// File: doc/pipe_dmem_responder.md
# pipe_dmem_responder

Multi-cycle data-memory responder serving load/store requests issued by the pipelined CPU's MEM stage. It accepts one request at a time over a valid/ready handshake, models a fixed access latency, performs the word access on an internal array, and returns a response over a second valid/ready handshake. While it is busy it drives a stall indication back to the pipeline. It is the memory-side counterpart of the CPU's data-memory port.

## Interface
Parameters:
- DEPTH, 128: number of 32-bit words in the array; must be a power of two.
- LATENCY, 2: wait cycles between request acceptance and response; must be ≥1.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_write_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  pipeline takes the response.
- rsp_rdata_o  out  32  load data; 0 for stores and errors.
- rsp_err_o  out  1  request was misaligned or out of range.
- busy_o  out  1  stall to pipeline; high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o, capture write, addr and wdata; load cnt=LATENCY-1; go to WAIT.
- WAIT:
  - If cnt≠0, decrement cnt.
  - If cnt==0, commit the access and go to RESP.
- Commit:
  - err = (addr[1:0]≠0) | (addr[31:2] ≥ DEPTH).
  - Store with no error: write wdata to word addr[31:2].
  - Load with no error: latch array word into rsp_rdata_o.
  - Any error: no array write; rdata=0; rsp_err_o=1.
  - Out-of-range addresses never alias onto valid words.
- RESP:
  - rsp_valid_o=1; rsp_rdata_o and rsp_err_o are held stable.
  - On rsp_ready_i, go to IDLE.
- req_ready_o is 0 in WAIT and RESP. A request cannot be accepted in the same cycle as a response handshake.
- The array is not cleared by reset.

## Timing
- Reset values:
  - state=IDLE, cnt=0.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, busy_o=0.
  - req_ready_o=1. Requests are ignored while rst_n is low.
- Acceptance at edge E:
  - busy_o rises after E.
  - The array write occurs at edge E+LATENCY.
  - rsp_valid_o rises after E+LATENCY.
- Minimum request period is LATENCY+2 cycles: accept, LATENCY wait cycles, one response cycle with rsp_ready_i=1.
- Read-after-write: a store commits before any later request can be accepted, so the next load observes it.
- Reset mid-operation: an uncommitted store is discarded, and any pending response is dropped without being delivered.
- rsp_ready_i is ignored outside RESP. req_* inputs are ignored outside IDLE.

## Structure
- Shared package pipe_mem_pkg holds:
  - the state enum (IDLE/WAIT/RESP);
  - the word and address width constants;
  - default DEPTH and LATENCY.
- Sub-module dmem_array: DEPTH×32 array, synchronous write enable, asynchronous read, no reset.
- The top level holds the FSM, the latency counter, the capture registers and the error check.

## Test plan
- Basic store/load (LATENCY=2, reset released):
  - Store 0xDEADBEEF to 0x10: accepted at edge 0; rsp_valid_o high after edge 2; rsp_err_o=0.
  - Load 0x10: rsp_rdata_o=0xDEADBEEF.
- Misaligned: load 0x13 returns rsp_err_o=1 and rdata=0. Store 0x11 with 0x1234 leaves words 0x10/0x14 unchanged.
- Out of range: store 0xCAFE0000 to 4*DEPTH returns rsp_err_o=1. Load 0x0 still returns its prior value (no aliasing).
- Response backpressure: hold rsp_ready_i=0 for 5 cycles. rsp_valid_o and rsp_rdata_o stay stable, req_ready_o=0, busy_o=1. Handshake on cycle 6, then IDLE.
- Reset during WAIT of a store 0x55AA55AA to 0x20: rsp_valid_o drops immediately and state=IDLE. A following load of 0x20 returns the pre-store value.
- Back-to-back (LATENCY=1): with req_valid_i held high and rsp_ready_i=1, requests are accepted every 3 cycles. Three sequential stores followed by loads return the correct data in order.
